// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared widths, op encodings and FSM states for the multiply/divide unit
package mdu_pkg;

  localparam int DEF_XLEN = 64;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_UREM = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step on a 65-bit partial remainder
module mdu_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem_in[XLEN-1:0], dividend_bit};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  // A set top bit on entry means the doubled remainder already exceeds any divisor.
  assign q_bit   = rem_in[XLEN] | ~diff[XLEN+1];
  assign rem_out = q_bit ? diff[XLEN:0] : shifted;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with single-cycle register write-back
// Optional signed divide for op=11 is enabled by defining MDU_SIGNED_DIV_EN.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      dest,
  output logic            busy,
  output logic            done,
  output logic            reg_write,
  output logic [4:0]      reg_write_dest,
  output logic [XLEN-1:0] reg_write_data
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      op_q;
  logic [4:0]      dest_q;
  logic [XLEN-1:0] a_q, b_q, acc_q;
  logic [XLEN:0]   rem_q, rem_step;
  logic            q_bit;
  logic [XLEN-1:0] mul_acc_nxt, quot_nxt, result;
  logic [XLEN-1:0] a_load, b_load;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (rem_q),
    .dividend_bit (a_q[XLEN-1]),
    .divisor      (b_q),
    .rem_out      (rem_step),
    .q_bit        (q_bit)
  );

  assign mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
  assign quot_nxt    = {acc_q[XLEN-2:0], q_bit};

`ifdef MDU_SIGNED_DIV_EN
  logic neg_q, sdiv_sel;
  assign sdiv_sel = (op == OP_SDIV);
  // Divide zero is excluded from negation so the all-ones quotient survives.
  assign a_load = (sdiv_sel && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign b_load = (sdiv_sel && operand_b[XLEN-1]) ? -operand_b : operand_b;
`else
  assign a_load = operand_a;
  assign b_load = operand_b;
`endif

  always_comb begin
    result = quot_nxt;
    case (op_q)
      OP_MUL:  result = mul_acc_nxt;
      OP_UREM: result = rem_step[XLEN-1:0];
      default: result = quot_nxt;
    endcase
`ifdef MDU_SIGNED_DIV_EN
    if (op_q == OP_SDIV && neg_q) result = -quot_nxt;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST_ITER) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_q           <= OP_MUL;
      dest_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      acc_q          <= '0;
      rem_q          <= '0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
`ifdef MDU_SIGNED_DIV_EN
      neg_q          <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            dest_q <= dest;
            a_q    <= a_load;
            b_q    <= b_load;
            acc_q  <= '0;
            rem_q  <= '0;
            cnt    <= '0;
`ifdef MDU_SIGNED_DIV_EN
            neg_q  <= sdiv_sel && (operand_a[XLEN-1] ^ operand_b[XLEN-1]) && (|operand_b);
`endif
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          a_q <= a_q << 1;
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_nxt;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= quot_nxt;
            rem_q <= rem_step;
          end
          if (cnt == LAST_ITER) begin
            reg_write_data <= result;
            reg_write_dest <= dest_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign reg_write = done;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  localparam logic [1:0] MUL = 2'b00, UDIV = 2'b01, UREM = 2'b10, SDIV = 2'b11;
  localparam int DONE_EDGES = 64;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [63:0] operand_a, operand_b;
  logic [4:0]  dest;
  logic        busy, done, reg_write;
  logic [4:0]  reg_write_dest;
  logic [63:0] reg_write_data;

  int total = 0;
  int bad   = 0;

  mul_div_unit dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .dest           (dest),
    .busy           (busy),
    .done           (done),
    .reg_write      (reg_write),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] d, output logic [63:0] res, output logic [4:0] dst, output int lat);
    op = o; operand_a = a; operand_b = b; dest = d; start = 1'b1;
    tick();
    start = 1'b0; operand_a = ~a; operand_b = ~b; dest = ~d;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    lat = -1; res = '0; dst = '0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done) begin
        lat = i; res = reg_write_data; dst = reg_write_dest;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(DONE_EDGES));
    tick();
    chk({tag, "_pulse_end"}, {62'd0, done, reg_write}, 64'd0);
  endtask

  logic [63:0] res;
  logic [4:0]  dst;
  int          lat, pulses, dones, rises;
  int          rise_t[3];
  logic        busy_prev;
  logic [63:0] cap_data;
  logic [4:0]  cap_dest;

  initial begin
    reset = 1'b1; start = 1'b0; op = MUL; operand_a = '0; operand_b = '0; dest = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_dest", 64'(reg_write_dest), 64'd0);
    chk("rst_data", reg_write_data, 64'd0);
    reset = 1'b0;
    tick();

    run_op("mul", MUL, 64'd916, 64'd3, 5'd7, res, dst, lat);
    chk("mul_data", res, 64'd2748);
    chk("mul_dest", 64'(dst), 64'd7);
    chk("mul_hold_data", reg_write_data, 64'd2748);

    run_op("udiv", UDIV, 64'd100, 64'd7, 5'd3, res, dst, lat);
    chk("udiv_data", res, 64'd14);
    chk("udiv_dest", 64'(dst), 64'd3);
    run_op("urem", UREM, 64'd100, 64'd7, 5'd4, res, dst, lat);
    chk("urem_data", res, 64'd2);
    run_op("udiv0", UDIV, 64'd5, 64'd0, 5'd5, res, dst, lat);
    chk("udiv0_data", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("urem0", UREM, 64'd5, 64'd0, 5'd6, res, dst, lat);
    chk("urem0_data", res, 64'd5);
    run_op("op11", SDIV, 64'd100, 64'd7, 5'd0, res, dst, lat);
    chk("op11_data", res, 64'd14);
    chk("op11_dest0", 64'(dst), 64'd0);
    run_op("mul_big", MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd31, res, dst, lat);
    chk("mul_big_data", res, 64'hFFFF_FFFF_FFFF_FFFD);

`ifdef MDU_SIGNED_DIV_EN
    run_op("sdiv", SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd8, res, dst, lat);
    chk("sdiv_data", res, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("sdiv_ovf", SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, res, dst, lat);
    chk("sdiv_ovf_data", res, 64'h8000_0000_0000_0000);
    run_op("sdiv0", SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 5'd10, res, dst, lat);
    chk("sdiv0_data", res, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // Second start while busy must be dropped.
    op = MUL; operand_a = 64'd916; operand_b = 64'd3; dest = 5'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    op = UDIV; operand_a = 64'd2; operand_b = 64'd2; dest = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0; cap_data = '0; cap_dest = '0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (reg_write) begin
        pulses++; cap_data = reg_write_data; cap_dest = reg_write_dest;
      end
    end
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_data", cap_data, 64'd2748);
    chk("ign_dest", 64'(cap_dest), 64'd7);

    op = MUL; operand_a = 64'd916; operand_b = 64'd3; dest = 5'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_data", reg_write_data, 64'd0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (reg_write) pulses++;
    end
    chk("midrst_no_write", 64'(pulses), 64'd0);
    run_op("mul67", MUL, 64'd6, 64'd7, 5'd2, res, dst, lat);
    chk("mul67_data", res, 64'd42);

    op = MUL; operand_a = 64'd2; operand_b = 64'd3; dest = 5'd1; start = 1'b1;
    dones = 0; rises = 0; busy_prev = busy;
    for (int i = 1; i <= 140; i++) begin
      tick();
      if (done) dones++;
      if (busy && !busy_prev) begin
        if (rises < 3) rise_t[rises] = i;
        rises++;
      end
      busy_prev = busy;
    end
    start = 1'b0;
    chk("b2b_accepts", 64'(rises), 64'd3);
    chk("b2b_dones", 64'(dones), 64'd2);
    chk("b2b_gap1", 64'(rise_t[1] - rise_t[0]), 64'd66);
    chk("b2b_gap2", 64'(rise_t[2] - rise_t[1]), 64'd66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
